// File: rtl/cs_link_pkg.sv
// cs_link_pkg: state encodings and beat-count helper shared by the cs_link slice.
package cs_link_pkg;
  localparam logic [3:0] MAIN_IDLE = 4'd0;
  localparam logic [3:0] MAIN_TYPE = 4'd1;
  localparam logic [3:0] CONF_BEGN = 4'd2;
  localparam logic [3:0] CONF_DONE = 4'd3;
  localparam logic [3:0] WORK_RDBG = 4'd4;
  localparam logic [3:0] WORK_RDGN = 4'd5;
  localparam logic [3:0] DTID_RDLO = 4'd6;
  localparam logic [3:0] DTID_RDHI = 4'd7;
  localparam logic [3:0] DTID_JUDG = 4'd8;
  localparam logic [3:0] DTID_DONE = 4'd9;
  localparam logic [3:0] DTID_MAKE = 4'd10;
  localparam logic [3:0] DTID_PLUS = 4'd11;
  localparam logic [3:0] DTID_WAIT = 4'd12;
  function automatic int nb_of(input int id_w, input int lane_w);
    return id_w / lane_w;
  endfunction
endpackage

// File: rtl/cs_link_tmo.sv
// cs_link_tmo: per-state watchdog; counts cycles in the current state, the current one included.
module cs_link_tmo #(
  parameter int TMO_W = 8
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [TMO_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? TMO_W'(1) : enable ? cnt_q + TMO_W'(1) : cnt_q;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = enable & (&cnt_q);
endmodule

// File: rtl/cs_link.sv
// cs_link: ID link FSM, receiver (link master) or ID generator; CS_LINK_TMO_EN adds a watchdog.
module cs_link
  import cs_link_pkg::*;
#(
  parameter int LANE_W    = 2,
  parameter int ID_W      = 4,
  parameter int MAX_RETRY = 3,
  parameter int TMO_W     = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              dev_grp,
  input  logic              fd_adc_conf,
  input  logic              adc_rxc,
  input  logic [1:0]        com_ctl_i,
  output logic [1:0]        com_ctl_o,
  output logic [1:0]        com_ctl_oe,
  input  logic [LANE_W-1:0] com_dat_i,
  output logic              fs_adc,
  output logic [ID_W-1:0]   dat_id,
  output logic              id_vld,
  output logic              id_err
);
  localparam int NB = nb_of(ID_W, LANE_W);
  localparam int IW = $clog2(2 * NB + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [IW-1:0] LAST = IW'(2 * NB - 1);
  logic [3:0]      state_q, state_d;
  logic [ID_W-1:0] dat_id_q, dat_id_d, data_q, data_d, check_q, check_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            mode_q, mode_d, id_vld_q, id_err_q, id_err_d, tmo_exp;
  always_comb begin
    state_d  = state_q;
    dat_id_d = dat_id_q;
    data_d   = data_q;
    check_d  = check_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    mode_d   = mode_q;
    id_err_d = 1'b0;
    case (state_q)
      MAIN_IDLE: if (fd_adc_conf) state_d = MAIN_TYPE;
      MAIN_TYPE: begin
        mode_d  = dev_grp;
        state_d = dev_grp ? CONF_BEGN : DTID_MAKE;
      end
      CONF_BEGN: if (&com_dat_i) state_d = CONF_DONE;
      CONF_DONE: if (~|com_dat_i) state_d = WORK_RDBG;
      WORK_RDBG: if (com_ctl_i[1]) state_d = WORK_RDGN;
      WORK_RDGN: if (!com_ctl_i[1]) begin
        state_d = DTID_RDLO;
        idx_d   = '0;
        retry_d = '0;
      end
      // shifting beats in from the LSB end leaves beat 0 in the MSBs after NB beats
      DTID_RDLO: if (com_ctl_i[0]) begin
        state_d = DTID_RDHI;
        if (idx_q < IW'(NB)) data_d = (data_q << LANE_W) | ID_W'(com_dat_i);
        else check_d = (check_q << LANE_W) | ID_W'(com_dat_i);
      end
      DTID_RDHI: if (!com_ctl_i[0]) begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == LAST) ? DTID_JUDG : DTID_RDLO;
      end
      DTID_JUDG:
        if (data_q == check_q && |data_q) state_d = DTID_DONE;
        else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          idx_d   = '0;
          state_d = DTID_RDLO;
        end else begin
          id_err_d = 1'b1;
          state_d  = WORK_RDBG;
        end
      DTID_DONE: begin
        dat_id_d = data_q;
        state_d  = WORK_RDBG;
      end
      DTID_MAKE: if (adc_rxc) state_d = DTID_PLUS;
      DTID_PLUS: begin
        dat_id_d = (&dat_id_q) ? ID_W'(1) : dat_id_q + ID_W'(1);
        state_d  = DTID_WAIT;
      end
      DTID_WAIT: if (!adc_rxc) state_d = DTID_MAKE;
      default:   state_d = MAIN_IDLE;
    endcase
    if (tmo_exp) begin
      id_err_d = 1'b1;
      state_d  = (state_q == CONF_BEGN || state_q == CONF_DONE) ? MAIN_IDLE : WORK_RDBG;
    end
  end
`ifdef CS_LINK_TMO_EN
  logic tmo_en;
  assign tmo_en = state_q == CONF_BEGN || state_q == CONF_DONE || state_q == WORK_RDGN ||
                  state_q == DTID_RDLO || state_q == DTID_RDHI;
  cs_link_tmo #(.TMO_W(TMO_W)) u_tmo (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .clear  (state_d != state_q),
    .enable (tmo_en),
    .expire (tmo_exp)
  );
`else
  assign tmo_exp = TMO_W < 1;
`endif
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= MAIN_IDLE;
      dat_id_q <= '0;
      data_q   <= '0;
      check_q  <= '0;
      idx_q    <= '0;
      retry_q  <= '0;
      mode_q   <= 1'b0;
      id_vld_q <= 1'b0;
      id_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dat_id_q <= dat_id_d;
      data_q   <= data_d;
      check_q  <= check_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      mode_q   <= mode_d;
      id_vld_q <= state_q == DTID_DONE;
      id_err_q <= id_err_d;
    end
  assign com_ctl_o  = {state_q == CONF_BEGN, state_q == CONF_DONE};
  assign com_ctl_oe = com_ctl_o;
  assign fs_adc     = mode_q ? state_q == WORK_RDGN : adc_rxc;
  assign dat_id     = dat_id_q;
  assign id_vld     = id_vld_q;
  assign id_err     = id_err_q;
endmodule
